// File: rtl/mul_accumulator.sv
// Accumulates handshaked multiplier products into a registered running sum,
// with sticky overflow, optional saturate-and-freeze, and a saturating beat count.
module mul_accumulator #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] product,
    input  logic             mul_ovf,
    input  logic             clear,
    output logic [WIDTH-1:0] acc,
    output logic             acc_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);
    localparam bit SAT_EN = (SATURATE != 0);

    typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             ovf_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH:0]   sum;
    logic             ovf_evt;
    logic             accept;

    assign in_ready = !reset && !clear && (state != SAT);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, acc} + {1'b0, product};
    assign ovf_evt  = mul_ovf | sum[WIDTH];

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        count_nxt = count;
        if (accept) begin
            count_nxt = (count == '1) ? count : count + CNT_W'(1);
            if (ovf_evt && SAT_EN) begin
                acc_nxt   = '1;
                ovf_nxt   = 1'b1;
                state_nxt = SAT;
            end else begin
                // wrap mode keeps running; ovf stays sticky once set
                acc_nxt   = sum[WIDTH-1:0];
                ovf_nxt   = ovf | ovf_evt;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            acc_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            count     <= count_nxt;
            acc_valid <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_mul_accumulator.sv
// Three accumulators (saturate, wrap, 2-bit counter) share one stimulus stream;
// a reference model predicts each edge and a monitor compares the queued results.
module tb_mul_accumulator;
    logic        clk = 1'b0;
    logic        reset, in_valid, mul_ovf, clear;
    logic [15:0] product;

    logic [2:0]       rdy, vld, ovfo;
    logic [2:0][15:0] acco;
    logic [7:0]       cnt0, cnt1;
    logic [1:0]       cnt2;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0][15:0] acc;
        logic [2:0]       ovf;
        logic [2:0][7:0]  cnt;
        logic [2:0]       vld;
    } exp_t;

    exp_t q[$];

    // reference model state
    int m_acc[3];
    bit m_ovf[3];
    int m_cnt[3];
    bit m_any[3];
    bit m_frz[3];
    bit satp[3]   = '{1'b1, 1'b0, 1'b1};
    int cntmax[3] = '{255, 255, 3};

    always #5 clk = ~clk;

    mul_accumulator #(.WIDTH(16), .CNT_W(8), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .product(product), .mul_ovf(mul_ovf), .clear(clear),
        .acc(acco[0]), .acc_valid(vld[0]), .ovf(ovfo[0]), .count(cnt0));

    mul_accumulator #(.WIDTH(16), .CNT_W(8), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .product(product), .mul_ovf(mul_ovf), .clear(clear),
        .acc(acco[1]), .acc_valid(vld[1]), .ovf(ovfo[1]), .count(cnt1));

    mul_accumulator #(.WIDTH(16), .CNT_W(2), .SATURATE(1)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .product(product), .mul_ovf(mul_ovf), .clear(clear),
        .acc(acco[2]), .acc_valid(vld[2]), .ovf(ovfo[2]), .count(cnt2));

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Drive one cycle: inputs are applied after the falling edge, the model predicts the
    // coming rising edge and queues the outcome for the monitor.
    task automatic step(input bit v, input logic [15:0] p, input bit mo, input bit c, input bit r);
        exp_t e;
        bit   er;
        int   s;
        bit   evt;
        in_valid = v; product = p; mul_ovf = mo; clear = c; reset = r;
        #1;
        for (int i = 0; i < 3; i++) begin
            er = !r && !c && !m_frz[i];
            chk("in_ready", i, {31'b0, rdy[i]}, {31'b0, er});
            if (r || c) begin
                m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_any[i] = 0; m_frz[i] = 0;
            end else if (v && er) begin
                s   = m_acc[i] + int'(p);
                evt = mo || (s > 65535);
                m_any[i] = 1;
                if (m_cnt[i] < cntmax[i]) m_cnt[i]++;
                if (evt) m_ovf[i] = 1;
                if (evt && satp[i]) begin
                    m_acc[i] = 65535;
                    m_frz[i] = 1;
                end else begin
                    m_acc[i] = s % 65536;
                end
            end
            e.acc[i] = m_acc[i][15:0];
            e.ovf[i] = m_ovf[i];
            e.cnt[i] = m_cnt[i][7:0];
            e.vld[i] = m_any[i];
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic beat(input logic [15:0] p);
        step(1'b1, p, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [2:0][7:0] ac;
        if (q.size() > 0) begin
            e = q.pop_front();
            ac[0] = cnt0; ac[1] = cnt1; ac[2] = {6'b0, cnt2};
            for (int i = 0; i < 3; i++) begin
                chk("acc", i, {16'b0, acco[i]}, {16'b0, e.acc[i]});
                chk("ovf", i, {31'b0, ovfo[i]}, {31'b0, e.ovf[i]});
                chk("count", i, {24'b0, ac[i]}, {24'b0, e.cnt[i]});
                chk("acc_valid", i, {31'b0, vld[i]}, {31'b0, e.vld[i]});
            end
        end
    end

    initial begin
        in_valid = 0; product = 0; mul_ovf = 0; clear = 0; reset = 1;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_any[i] = 0; m_frz[i] = 0;
        end
        @(negedge clk);
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 0);
        // two back-to-back beats
        beat(16'd12); beat(16'd5);
        step(0, 16'h0, 0, 0, 0);
        // preload 0xFFF0 then overflow; ignored beats while frozen (wrap instance keeps going)
        step(0, 16'h0, 0, 1, 0);
        beat(16'h8000); beat(16'h7FF0); beat(16'h0020);
        for (int k = 0; k < 5; k++) beat(16'h0001);
        step(0, 16'h0, 0, 1, 0);
        step(0, 16'h0, 0, 0, 0);
        // wrap then sticky ovf
        beat(16'h8000); beat(16'h7FF0); beat(16'h0020); beat(16'h0003);
        // mul_ovf with small and zero product
        step(0, 16'h0, 0, 1, 0);
        step(1, 16'h0001, 1, 0, 0);
        step(0, 16'h0, 0, 1, 0);
        step(1, 16'h0000, 1, 0, 0);
        // exact-fit boundary: 0xFFF0 + 0x000F is not overflow; one more is
        step(0, 16'h0, 0, 1, 0);
        beat(16'h8000); beat(16'h7FF0); beat(16'h000F); beat(16'h0001);
        // clear wins over a presented beat; beat held and taken next cycle
        step(1, 16'd7, 0, 1, 0);
        beat(16'd7);
        // counter saturation, then reset in the middle of a run
        step(0, 16'h0, 0, 1, 0);
        for (int k = 0; k < 5; k++) beat(16'd1);
        step(0, 16'h0, 0, 1, 0);
        beat(16'd1); beat(16'd1);
        step(1, 16'd1, 0, 0, 1);
        step(0, 16'h0, 0, 0, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] p;
            case ($urandom % 4)
                0: p = 16'($urandom % 256);
                1: p = 16'($urandom % 4096);
                2: p = 16'($urandom);
                default: p = 16'h0;
            endcase
            step(($urandom % 4) != 0, p, ($urandom % 32) == 0,
                 ($urandom % 40) == 0, ($urandom % 200) == 0);
        end
        step(0, 16'h0, 0, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
